// File: rtl/spi_xfer_core.sv
// SPI master shift engine: std/dual/quad transfers of 1..DATA_WIDTH bits with CPOL/CPHA, bit order and SCK divider.
// Optional sticky done interrupt when SPI_XFER_IRQ_EN is defined; otherwise irq_o is tied low.
module spi_xfer_core #(
  parameter int NSS_NUM    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [1:0]                      cfg_mode_i,
  input  logic                            cfg_rx_i,
  input  logic                            cfg_cpol_i,
  input  logic                            cfg_cpha_i,
  input  logic                            cfg_lsb_i,
  input  logic [DIV_WIDTH-1:0]            cfg_div_i,
  input  logic [NSS_NUM-1:0]              cfg_nss_i,
  input  logic [$clog2(DATA_WIDTH):0]     cfg_nbits_i,
  input  logic                            xfer_valid_i,
  output logic                            xfer_ready_o,
  input  logic [DATA_WIDTH-1:0]           xfer_tx_i,
  output logic                            rx_valid_o,
  output logic [DATA_WIDTH-1:0]           rx_data_o,
  output logic                            busy_o,
  input  logic                            irq_clr_i,
  output logic                            spi_sck_o,
  output logic [NSS_NUM-1:0]              spi_nss_o,
  output logic [3:0]                      spi_io_en_o,
  input  logic [3:0]                      spi_io_in_i,
  output logic [3:0]                      spi_io_out_o,
  output logic                            irq_o
);
  localparam int NW = $clog2(DATA_WIDTH) + 1;
  localparam int EW = NW + 1;
  localparam logic [NW-1:0] DW_N = NW'(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, DONE} state_t;

  state_t                 state_q;
  logic [DIV_WIDTH-1:0]   hcnt_q, div_q;
  logic [EW-1:0]          ecnt_q;
  logic [DATA_WIDTH-1:0]  sr_q, acc_q, rx_data_q;
  logic [1:0]             mode_q;
  logic                   half_rx_q, cpol_q, cpha_q, lsb_q;
  logic [NW-1:0]          nb_q, slots_q;
  logic                   ready_q, busy_q, rx_valid_q, sck_q;
  logic [NSS_NUM-1:0]     nss_q;
  logic [3:0]             en_q, out_q;

  logic [1:0]             mode_in;
  logic                   half_rx_in;
  logic [NW-1:0]          nb_in, beats_in, slots_in;
  logic [DATA_WIDTH-1:0]  txm_in, sr_in;
  logic [2:0]             step;
  logic [3:0]             in_bits;
  logic [DATA_WIDTH-1:0]  sr_next, acc_next, rx_final;
  logic                   lead_edge;

  // Next beat sits at the top of sr for MSB-first and at the bottom for LSB-first.
  function automatic logic [3:0] beat_of(input logic [DATA_WIDTH-1:0] s, input logic [1:0] m,
                                         input logic l, input logic r);
    logic [3:0] b;
    b = 4'b0000;
    if (!r) begin
      case (m)
        2'd1:    b = l ? {2'b00, s[1:0]} : {2'b00, s[DATA_WIDTH-1 -: 2]};
        2'd2:    b = l ? s[3:0] : s[DATA_WIDTH-1 -: 4];
        default: b = {3'b000, (l ? s[0] : s[DATA_WIDTH-1])};
      endcase
    end
    return b;
  endfunction

  function automatic logic [3:0] en_of(input logic [1:0] m, input logic r);
    case (m)
      2'd1:    return r ? 4'b0000 : 4'b0011;
      2'd2:    return r ? 4'b0000 : 4'b1111;
      default: return 4'b0001;
    endcase
  endfunction

  always_comb begin
    mode_in    = (cfg_mode_i == 2'd3) ? 2'd0 : cfg_mode_i;
    half_rx_in = (mode_in != 2'd0) && cfg_rx_i;
    nb_in      = (cfg_nbits_i == '0) ? DW_N : cfg_nbits_i;
    case (mode_in)
      2'd1: begin
        beats_in = (nb_in + NW'(1)) >> 1;
        slots_in = beats_in << 1;
      end
      2'd2: begin
        beats_in = (nb_in + NW'(3)) >> 2;
        slots_in = beats_in << 2;
      end
      default: begin
        beats_in = nb_in;
        slots_in = nb_in;
      end
    endcase
    txm_in = xfer_tx_i & ~({DATA_WIDTH{1'b1}} << nb_in);
    sr_in  = cfg_lsb_i ? txm_in : (txm_in << (DW_N - nb_in));
  end

  always_comb begin
    case (mode_q)
      2'd1: begin
        step    = 3'd2;
        in_bits = {2'b00, spi_io_in_i[1:0]};
      end
      2'd2: begin
        step    = 3'd4;
        in_bits = spi_io_in_i;
      end
      default: begin
        step    = 3'd1;
        in_bits = {3'b000, spi_io_in_i[1]};
      end
    endcase
    sr_next  = lsb_q ? (sr_q >> step) : (sr_q << step);
    acc_next = lsb_q ? ((acc_q >> step) | ({in_bits, {(DATA_WIDTH-4){1'b0}}} << (3'd4 - step)))
                     : ((acc_q << step) | DATA_WIDTH'(in_bits));
    // Padding lands above the data for LSB-first and below it for MSB-first.
    rx_final = lsb_q ? ((acc_q >> (DW_N - slots_q)) & ~({DATA_WIDTH{1'b1}} << nb_q))
                     : (acc_q >> (slots_q - nb_q));
  end

  assign lead_edge = ~ecnt_q[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      hcnt_q     <= '0;
      div_q      <= '0;
      ecnt_q     <= '0;
      sr_q       <= '0;
      acc_q      <= '0;
      rx_data_q  <= '0;
      mode_q     <= 2'd0;
      half_rx_q  <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      nb_q       <= '0;
      slots_q    <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      sck_q      <= 1'b0;
      nss_q      <= '1;
      en_q       <= 4'b0000;
      out_q      <= 4'b0000;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sck_q <= cfg_cpol_i;
          if (xfer_valid_i && ready_q) begin
            state_q   <= LEAD;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            mode_q    <= mode_in;
            half_rx_q <= half_rx_in;
            cpol_q    <= cfg_cpol_i;
            cpha_q    <= cfg_cpha_i;
            lsb_q     <= cfg_lsb_i;
            div_q     <= cfg_div_i;
            hcnt_q    <= cfg_div_i;
            nb_q      <= nb_in;
            slots_q   <= slots_in;
            ecnt_q    <= {beats_in, 1'b0};
            sr_q      <= sr_in;
            acc_q     <= '0;
            nss_q     <= ~cfg_nss_i;
            en_q      <= en_of(mode_in, cfg_rx_i);
            out_q     <= beat_of(sr_in, mode_in, cfg_lsb_i, half_rx_in);
          end
        end
        LEAD: begin
          if (hcnt_q == '0) begin
            state_q <= SHIFT;
            hcnt_q  <= div_q;
          end else begin
            hcnt_q <= hcnt_q - 1'b1;
          end
        end
        SHIFT: begin
          if (hcnt_q == '0) begin
            hcnt_q <= div_q;
            sck_q  <= ~sck_q;
            ecnt_q <= ecnt_q - 1'b1;
            if (lead_edge != cpha_q) begin
              acc_q <= acc_next;
            end else begin
              sr_q  <= sr_next;
              out_q <= cpha_q ? beat_of(sr_q, mode_q, lsb_q, half_rx_q)
                              : beat_of(sr_next, mode_q, lsb_q, half_rx_q);
            end
            if (ecnt_q == EW'(1)) state_q <= TRAIL;
          end else begin
            hcnt_q <= hcnt_q - 1'b1;
          end
        end
        TRAIL: begin
          if (hcnt_q == '0) begin
            state_q    <= DONE;
            nss_q      <= '1;
            en_q       <= 4'b0000;
            out_q      <= 4'b0000;
            rx_valid_q <= 1'b1;
            rx_data_q  <= rx_final;
          end else begin
            hcnt_q <= hcnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SPI_XFER_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)                 irq_q <= 1'b0;
    else if (state_q == DONE)  irq_q <= 1'b1;
    else if (irq_clr_i)        irq_q <= 1'b0;
  end
  assign irq_o = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr_i;
  assign irq_o = 1'b0;
`endif

  assign xfer_ready_o = ready_q;
  assign busy_o       = busy_q;
  assign rx_valid_o   = rx_valid_q;
  assign rx_data_o    = rx_data_q;
  assign spi_sck_o    = sck_q;
  assign spi_nss_o    = nss_q;
  assign spi_io_en_o  = en_q;
  assign spi_io_out_o = out_q;

endmodule

// File: tb/tb_spi_xfer_core.sv
// Bench for spi_xfer_core: directed plus random transfers checked against a bit-stream model.
module tb_spi_xfer_core;
  localparam int NSS_NUM = 4;
  localparam int DW      = 32;
  localparam int DIVW    = 8;
  localparam int NW      = $clog2(DW) + 1;
`ifdef SPI_XFER_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] cfg_mode = 2'd0;
  logic cfg_rx = 1'b0, cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb = 1'b0;
  logic [DIVW-1:0] cfg_div = '0;
  logic [NSS_NUM-1:0] cfg_nss = 4'b0001;
  logic [NW-1:0] cfg_nbits = '0;
  logic xfer_valid = 1'b0, xfer_ready;
  logic [DW-1:0] xfer_tx = '0, rx_data;
  logic rx_valid, busy, irq_clr = 1'b0, sck, irq;
  logic [NSS_NUM-1:0] nss;
  logic [3:0] io_en, io_in, io_out, drv = 4'b0000;
  logic loop = 1'b0;
  logic [3:0] pre [4];
  int errors = 0, checks = 0;

  assign io_in = loop ? {2'b00, io_out[0], 1'b0} : drv;

  spi_xfer_core #(.NSS_NUM(NSS_NUM), .DATA_WIDTH(DW), .DIV_WIDTH(DIVW)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_mode_i(cfg_mode), .cfg_rx_i(cfg_rx), .cfg_cpol_i(cfg_cpol),
    .cfg_cpha_i(cfg_cpha), .cfg_lsb_i(cfg_lsb), .cfg_div_i(cfg_div), .cfg_nss_i(cfg_nss),
    .cfg_nbits_i(cfg_nbits), .xfer_valid_i(xfer_valid), .xfer_ready_o(xfer_ready),
    .xfer_tx_i(xfer_tx), .rx_valid_o(rx_valid), .rx_data_o(rx_data), .busy_o(busy),
    .irq_clr_i(irq_clr), .spi_sck_o(sck), .spi_nss_o(nss), .spi_io_en_o(io_en),
    .spi_io_in_i(io_in), .spi_io_out_o(io_out), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_xfer(input logic [1:0] m, input logic r, input logic cp, input logic ph,
                         input logic l, input logic [DIVW-1:0] dv, input logic [NSS_NUM-1:0] sel,
                         input logic [NW-1:0] nbits, input logic [DW-1:0] tx, input logic lp,
                         input logic use_pre, input string tag, output logic [DW-1:0] got);
    int b, nb, beats, h, ncyc, nss_low, nedge, last_edge, gap_bad, nss_bad, en_bad, idx, line;
    logic [3:0] q_out[$], q_in[$];
    logic [3:0] prev_out, prev_in, exp_en, e;
    logic prev_sck, done_seen, half_rx, half_tx, bitv;
    logic [NSS_NUM-1:0] nss_done;
    logic [DW-1:0] exp_rx;

    nb      = (nbits == 0) ? DW : int'(nbits);
    b       = (m == 2'd1) ? 2 : (m == 2'd2) ? 4 : 1;
    beats   = (nb + b - 1) / b;
    h       = int'(dv) + 1;
    half_rx = (m == 2'd1 || m == 2'd2) && r;
    half_tx = (m == 2'd1 || m == 2'd2) && !r;
    exp_en  = (m == 2'd1) ? (r ? 4'b0000 : 4'b0011) : (m == 2'd2) ? (r ? 4'b0000 : 4'b1111) : 4'b0001;

    cfg_mode = m; cfg_rx = r; cfg_cpol = cp; cfg_cpha = ph; cfg_lsb = l; cfg_div = dv;
    cfg_nss = sel; cfg_nbits = nbits; xfer_tx = tx; loop = lp;
    drv = use_pre ? pre[0] : 4'($urandom);
    @(negedge clk);
    check({tag, ".idle_sck"}, sck, cp);
    check({tag, ".ready"}, xfer_ready, 1);
    xfer_valid = 1'b1;
    @(negedge clk);
    xfer_valid = 1'b0;

    ncyc = 0; nss_low = 0; nedge = 0; last_edge = 0; gap_bad = 0; nss_bad = 0; en_bad = 0;
    done_seen = 1'b0; got = '0; nss_done = '0;
    prev_sck = cp; prev_out = io_out;
    prev_in = lp ? {2'b00, io_out[0], 1'b0} : drv;
    while (!done_seen && ncyc < 5000) begin
      if (nss !== {NSS_NUM{1'b1}}) begin
        nss_low++;
        if (nss !== ~sel) nss_bad++;
        if (io_en !== exp_en) en_bad++;
      end
      if (sck !== prev_sck) begin
        if (nedge > 0 && (ncyc - last_edge) != h) gap_bad++;
        last_edge = ncyc;
        nedge++;
        if ((prev_sck === cp) != ph) begin
          q_out.push_back(prev_out);
          q_in.push_back(prev_in);
          if (use_pre) drv = pre[q_in.size() % 4];
        end
      end
      if (!use_pre && !lp) drv = 4'($urandom);
      prev_sck = sck;
      prev_out = io_out;
      prev_in  = lp ? {2'b00, io_out[0], 1'b0} : drv;
      if (rx_valid === 1'b1) begin
        done_seen = 1'b1;
        got       = rx_data;
        nss_done  = nss;
        irq_clr   = 1'b1;
      end else begin
        @(negedge clk);
        ncyc++;
      end
    end
    check({tag, ".done_seen"}, done_seen, 1);
    check({tag, ".nss_at_done"}, nss_done, {NSS_NUM{1'b1}});
    @(negedge clk);
    irq_clr = 1'b0;
    check({tag, ".rxv_pulse"}, rx_valid, 0);
    check({tag, ".ready_after"}, xfer_ready, 1);
    check({tag, ".busy_after"}, busy, 0);
    check({tag, ".irq"}, irq, IRQ_EN);
    check({tag, ".sck_idle_after"}, sck, cp);

    check({tag, ".nss_low_cycles"}, nss_low, 2 * h + 2 * beats * h);
    check({tag, ".nss_sel"}, nss_bad, 0);
    check({tag, ".io_en"}, en_bad, 0);
    check({tag, ".sck_half"}, gap_bad, 0);
    check({tag, ".sck_edges"}, nedge, 2 * beats);
    check({tag, ".samples"}, q_in.size(), beats);

    if (!half_rx) begin
      for (int k = 0; k < beats && k < q_out.size(); k++) begin
        e = 4'b0000;
        for (int j = 0; j < b; j++) begin
          idx  = k * b + j;
          bitv = (idx < nb) ? (l ? tx[idx] : tx[nb - 1 - idx]) : 1'b0;
          line = l ? j : b - 1 - j;
          e[line] = bitv;
        end
        check($sformatf("%s.tx_beat%0d", tag, k), q_out[k], e);
      end
    end
    if (!half_tx) begin
      exp_rx = '0;
      for (int k = 0; k < beats && k < q_in.size(); k++) begin
        for (int j = 0; j < b; j++) begin
          idx  = k * b + j;
          line = l ? j : b - 1 - j;
          bitv = (b == 1) ? q_in[k][1] : q_in[k][line];
          if (idx < nb) begin
            if (l) exp_rx[idx] = bitv;
            else   exp_rx[nb - 1 - idx] = bitv;
          end
        end
      end
      check({tag, ".rx_data"}, got, exp_rx);
    end
  endtask

  initial begin
    logic [DW-1:0] got;
    int pulses;
    pre[0] = 4'b0001; pre[1] = 4'b0010; pre[2] = 4'b0011; pre[3] = 4'b0000;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.ready", xfer_ready, 1);
    check("rst.busy", busy, 0);
    check("rst.rx_valid", rx_valid, 0);
    check("rst.rx_data", rx_data, 0);
    check("rst.sck", sck, 0);
    check("rst.nss", nss, {NSS_NUM{1'b1}});
    check("rst.io_en", io_en, 0);
    check("rst.io_out", io_out, 0);
    check("rst.irq", irq, 0);
    rst = 1'b0;

    do_xfer(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0001, NW'(8), 32'hA5, 1'b1, 1'b0, "tp1", got);
    check("tp1.rx_const", got, 32'h0000_00A5);
    do_xfer(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 4'b0010, NW'(16), 32'h1234, 1'b0, 1'b0, "tp2", got);
    do_xfer(2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 4'b0100, NW'(8), 32'h0, 1'b0, 1'b1, "tp3", got);
    check("tp3.rx_const", got, 32'h0000_0039);
    do_xfer(2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 4'b1000, NW'(0), 32'hDEAD_BEEF, 1'b1, 1'b0, "tp4", got);
    check("tp4.rx_const", got, 32'hDEAD_BEEF);

    cfg_mode = 2'd0; cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_div = 8'd2; cfg_nbits = NW'(16);
    cfg_nss = 4'b0001; loop = 1'b0; xfer_tx = $urandom;
    @(negedge clk);
    xfer_valid = 1'b1;
    @(negedge clk);
    xfer_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid.busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid.nss", nss, {NSS_NUM{1'b1}});
    check("mid.ready", xfer_ready, 1);
    check("mid.busy", busy, 0);
    check("mid.rx_valid", rx_valid, 0);
    check("mid.io_en", io_en, 0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (rx_valid === 1'b1) pulses++;
    end
    check("mid.no_rxv", pulses, 0);
    do_xfer(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 4'b0010, NW'(12), 32'h0ABC, 1'b1, 1'b0, "post_rst", got);
    check("post_rst.rx_const", got, 32'h0000_0ABC);

    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    @(negedge clk);
    check("irq.cleared", irq, 0);

    for (int i = 0; i < 12; i++) begin
      do_xfer(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              DIVW'($urandom_range(0, 2)), NSS_NUM'(1 << $urandom_range(0, NSS_NUM - 1)),
              NW'($urandom_range(0, DW)), $urandom, 1'b0, 1'b0, $sformatf("rnd%0d", i), got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_xfer_core.md
Name: spi_xfer_core

Overview:
- Parametrised SPI master shift engine: one transfer of 1..DATA_WIDTH bits per request, in std (1-bit), dual (2-bit) or quad (4-bit) mode, with CPOL/CPHA, MSB/LSB-first, programmable SCK divider and NSS_NUM chip selects.
- Drives the SPI pad-level signals (sck, nss, 4-bit io with per-line output enable) and sits between the SPI register/FIFO front-end and the pads.

Parameters:
- NSS_NUM, 4, number of active-low chip-select lines.
- DATA_WIDTH, 32, maximum bits per transfer; must be a multiple of 4.
- DIV_WIDTH, 8, width of the SCK half-period divider.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  synchronous reset, active-high.
- cfg_mode_i  in  2  0 std, 1 dual, 2 quad, 3 treated as std.
- cfg_rx_i  in  1  dual/quad direction: 1 receive, 0 transmit. Ignored in std mode.
- cfg_cpol_i  in  1  SCK idle level.
- cfg_cpha_i  in  1  clock phase.
- cfg_lsb_i  in  1  1 = LSB first.
- cfg_div_i  in  DIV_WIDTH  half period H = cfg_div_i+1 clk cycles.
- cfg_nss_i  in  NSS_NUM  one-hot target select.
- cfg_nbits_i  in  $clog2(DATA_WIDTH)+1  bit count; 0 means DATA_WIDTH.
- xfer_valid_i  in  1  start request.
- xfer_ready_o  out  1  engine idle; accept when valid & ready.
- xfer_tx_i  in  DATA_WIDTH  transmit data, right-aligned.
- rx_valid_o  out  1  one-cycle pulse: rx_data_o valid.
- rx_data_o  out  DATA_WIDTH  received data, right-aligned, upper bits zero.
- busy_o  out  1  transfer in progress.
- irq_clr_i  in  1  clears irq_o.
- spi_sck_o  out  1  serial clock.
- spi_nss_o  out  NSS_NUM  chip selects, active-low.
- spi_io_en_o  out  4  per-line output enable.
- spi_io_in_i  in  4  pad inputs.
- spi_io_out_o  out  4  pad outputs.
- irq_o  out  1  transfer-done interrupt.

Behaviour:
- Reset values: xfer_ready_o=1, busy_o=0, rx_valid_o=0, rx_data_o=0, spi_sck_o=0, spi_nss_o=all 1, spi_io_en_o=0, spi_io_out_o=0, irq_o=0.
- Reset mid-transfer: return to IDLE in the next cycle with all reset values; no rx_valid_o pulse.
- All cfg_* inputs and xfer_tx_i are latched on accept and stay stable for the whole transfer.
- Bits per beat B = 1/2/4. Beats = ceil(nbits/B). Pad bits beyond nbits are transmitted as 0 and discarded on receive.
- FSM states:
  - IDLE: ready=1; sck tracks cfg_cpol_i (registered).
  - LEAD: H cycles; nss[sel] low; first beat driven.
  - SHIFT: 2*beats*H cycles; sck toggles every H cycles.
  - TRAIL: H cycles; sck at CPOL; nss still low.
  - DONE: 1 cycle; nss high, rx_valid_o=1, then IDLE.
- CPHA=0: sample on leading edge, shift out on trailing edge. CPHA=1: shift out on leading edge, sample on trailing edge.
- Sampling registers spi_io_in_i in the same clk cycle the edge is generated.
- Std mode: io0 = MOSI, io1 = MISO, en=4'b0001, full duplex.
- Dual mode: en=4'b0011 when transmitting, 4'b0000 when receiving.
- Quad mode: en=4'b1111 when transmitting, 4'b0000 when receiving.
- Within a beat, the highest io line carries the most significant bit.
- MSB-first: first bit sent is tx[nbits-1]; last bit received lands at rx bit 0.
- LSB-first: first bit sent is tx[0]; first bit received lands at rx bit 0.
- Example timing: std mode, 8 bits, div=0 → nss low for exactly 18 cycles; rx_valid_o pulses the cycle nss rises.
- valid asserted while busy: held off by ready=0 (no drop, no queue).
- Back-to-back: a new accept is possible in the IDLE cycle following DONE, so nss is high for at least 1 cycle between transfers.

Optional Feature:
- Macro: SPI_XFER_IRQ_EN.
- Defined: irq_o is sticky, set in the DONE cycle and cleared by irq_clr_i. If set and clear occur in the same cycle, set wins.
- Undefined: irq_o is tied to 0 and irq_clr_i is ignored.

Test Plan:
- Std, CPOL=0, CPHA=0, MSB-first, nbits=8, div=0, tx=0xA5, io1 looped to io0 → MOSI bits 1,0,1,0,0,1,0,1; rx_data_o=0x000000A5; nss0 low 18 cycles.
- Quad tx, nbits=16, tx=0x1234, div=1 → io[3:0] nibbles 1,2,3,4 on successive beats; en=4'b1111; sck half period = 2 cycles.
- Dual rx, LSB-first, nbits=8, io[1:0] driven with pairs 2'b01, 2'b10, 2'b11, 2'b00 → rx_data_o=0x39; en=4'b0000.
- CPOL=1, CPHA=1, nbits=0 (=32), tx=0xDEADBEEF, loopback → rx_data_o=0xDEADBEEF; sck idles high.
- rst_i pulsed mid-SHIFT → nss all high and ready=1 next cycle; no rx_valid_o; next transfer completes normally.
- With SPI_XFER_IRQ_EN defined: irq_clr_i asserted in the DONE cycle → irq_o=1. A later irq_clr_i → irq_o=0.
